// File: rtl/mdu_pkg.sv
// Shared MDU opcodes, FSM state type and widths.
// MADD-family codes are decoded only when MDU_MADD_EN is defined.
package mdu_pkg;

  localparam int MDU_OP_W = 4;

  localparam logic [MDU_OP_W-1:0] MDU_MULT  = 4'd0;
  localparam logic [MDU_OP_W-1:0] MDU_MULTU = 4'd1;
  localparam logic [MDU_OP_W-1:0] MDU_DIV   = 4'd2;
  localparam logic [MDU_OP_W-1:0] MDU_DIVU  = 4'd3;
  localparam logic [MDU_OP_W-1:0] MDU_MTHI  = 4'd4;
  localparam logic [MDU_OP_W-1:0] MDU_MTLO  = 4'd5;
  localparam logic [MDU_OP_W-1:0] MDU_MADD  = 4'd6;
  localparam logic [MDU_OP_W-1:0] MDU_MADDU = 4'd7;
  localparam logic [MDU_OP_W-1:0] MDU_MSUB  = 4'd8;
  localparam logic [MDU_OP_W-1:0] MDU_MSUBU = 4'd9;

  typedef enum logic {IDLE, RUN} state_t;

endpackage

// File: rtl/mdu_div.sv
// Combinational signed/unsigned divider: LO-side quotient, HI-side remainder, zero latency.
// No backpressure; divide-by-zero gives quo=all ones, rem=a; MIN/-1 gives quo=MIN, rem=0.
module mdu_div
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             is_signed,
  output logic [WIDTH-1:0] quo,
  output logic [WIDTH-1:0] rem
);

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag, q_mag, r_mag;

  // Magnitude division; MIN's magnitude fits as unsigned, so MIN/-1 wraps back to MIN naturally.
  always_comb begin
    a_neg = is_signed & a[WIDTH-1];
    b_neg = is_signed & b[WIDTH-1];
    a_mag = a_neg ? -a : a;
    b_mag = b_neg ? -b : b;
    q_mag = '0;
    r_mag = '0;
    if (b == '0) begin
      quo = '1;
      rem = a;
    end else begin
      q_mag = a_mag / b_mag;
      r_mag = a_mag % b_mag;
      quo   = (a_neg ^ b_neg) ? -q_mag : q_mag;
      rem   = a_neg ? -r_mag : r_mag;
    end
  end

endmodule

// File: rtl/mdu_core.sv
// Multi-cycle multiply/divide unit with HI/LO; commits after MULT_CYCLES/DIV_CYCLES, MTHI/MTLO in 1 edge.
// busy holds while an op is in flight and start is ignored then; MDU_MADD_EN adds MADD/MADDU/MSUB/MSUBU.
module mdu_core
  import mdu_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [MDU_OP_W-1:0] MDUOp,
  input  logic [WIDTH-1:0]    A,
  input  logic [WIDTH-1:0]    B,
  output logic                busy,
  output logic [WIDTH-1:0]    HI,
  output logic [WIDTH-1:0]    LO
);

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   hi_q, lo_q;

  logic               op_mul, op_div, op_signed, op_timed;
  logic [2*WIDTH-1:0] a_ext, b_ext, prod, mul_res;
  logic [WIDTH-1:0]   quo, rem;

  // One 2W x 2W multiplier serves both signednesses: sign- or zero-extend, keep the low 2W bits.
  always_comb begin
    op_mul    = (MDUOp == MDU_MULT) || (MDUOp == MDU_MULTU);
    op_div    = (MDUOp == MDU_DIV)  || (MDUOp == MDU_DIVU);
    op_signed = (MDUOp == MDU_MULT) || (MDUOp == MDU_DIV);
`ifdef MDU_MADD_EN
    op_mul    = op_mul || (MDUOp == MDU_MADD) || (MDUOp == MDU_MADDU)
                       || (MDUOp == MDU_MSUB) || (MDUOp == MDU_MSUBU);
    op_signed = op_signed || (MDUOp == MDU_MADD) || (MDUOp == MDU_MSUB);
`endif
    op_timed  = op_mul || op_div;
    a_ext     = {{WIDTH{op_signed & A[WIDTH-1]}}, A};
    b_ext     = {{WIDTH{op_signed & B[WIDTH-1]}}, B};
    prod      = a_ext * b_ext;
    mul_res   = prod;
`ifdef MDU_MADD_EN
    if ((MDUOp == MDU_MADD) || (MDUOp == MDU_MADDU))
      mul_res = {HI, LO} + prod;
    else if ((MDUOp == MDU_MSUB) || (MDUOp == MDU_MSUBU))
      mul_res = {HI, LO} - prod;
`endif
  end

  mdu_div #(.WIDTH(WIDTH)) u_div (
    .a         (A),
    .b         (B),
    .is_signed (op_signed),
    .quo       (quo),
    .rem       (rem)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      cnt   <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      HI    <= '0;
      LO    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (op_timed) begin
              {hi_q, lo_q} <= op_div ? {rem, quo} : mul_res;
              cnt          <= op_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
              busy         <= 1'b1;
              state        <= RUN;
            end else if (MDUOp == MDU_MTHI) begin
              HI <= A;
            end else if (MDUOp == MDU_MTLO) begin
              LO <= A;
            end
          end
        end
        RUN: begin
          cnt <= cnt - CNT_W'(1);
          // Final count: publish both halves together so HI/LO never show a partial result.
          if (cnt <= CNT_W'(1)) begin
            HI    <= hi_q;
            LO    <= lo_q;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_core.sv
// Self-checking bench for mdu_core: directed cases plus randomized ops against an arithmetic reference model.
module tb_mdu_core;

  localparam int W  = 32;
  localparam int MC = 5;
  localparam int DC = 10;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [3:0]    MDUOp;
  logic [W-1:0]  A, B;
  logic          busy;
  logic [W-1:0]  HI, LO;

  int            n_cmp = 0;
  int            n_bad = 0;
  logic [31:0]   m_hi = '0;
  logic [31:0]   m_lo = '0;

  mdu_core #(.WIDTH(W), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .MDUOp (MDUOp),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .HI    (HI),
    .LO    (LO)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Architectural effect of one accepted op on the model HI/LO; returns its busy latency (0 = immediate/no-op).
  task automatic ref_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, output int lat);
    longint      sa, sb;
    int          da, db;
    logic [63:0] p, acc;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    da  = $signed(a);
    db  = $signed(b);
    acc = {m_hi, m_lo};
    lat = 0;
    case (op)
      4'd0: begin p = sa * sb; {m_hi, m_lo} = p; lat = MC; end
      4'd1: begin p = {32'b0, a} * {32'b0, b}; {m_hi, m_lo} = p; lat = MC; end
      4'd2: begin
        lat = DC;
        if (b == 0) begin m_lo = 32'hFFFF_FFFF; m_hi = a; end
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin m_lo = 32'h8000_0000; m_hi = 0; end
        else begin m_lo = da / db; m_hi = da % db; end
      end
      4'd3: begin
        lat = DC;
        if (b == 0) begin m_lo = 32'hFFFF_FFFF; m_hi = a; end
        else begin m_lo = a / b; m_hi = a % b; end
      end
      4'd4: m_hi = a;
      4'd5: m_lo = a;
`ifdef MDU_MADD_EN
      4'd6: begin p = sa * sb; {m_hi, m_lo} = acc + p; lat = MC; end
      4'd7: begin p = {32'b0, a} * {32'b0, b}; {m_hi, m_lo} = acc + p; lat = MC; end
      4'd8: begin p = sa * sb; {m_hi, m_lo} = acc - p; lat = MC; end
      4'd9: begin p = {32'b0, a} * {32'b0, b}; {m_hi, m_lo} = acc - p; lat = MC; end
`endif
      default: ;
    endcase
  endtask

  // Called at a falling edge; returns at the falling edge of cycle N+1, ready for a back-to-back op.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int inj, input logic [3:0] inj_op, input logic [31:0] inj_a);
    logic [63:0] old;
    int          lat;
    old = {m_hi, m_lo};
    ref_op(op, a, b, lat);
    start = 1'b1; MDUOp = op; A = a; B = b;
    for (int c = 1; c <= lat; c++) begin
      @(negedge clk);
      check($sformatf("busy_run op%0d c%0d", op, c), {63'b0, busy}, 64'd1);
      check($sformatf("hilo_hold op%0d c%0d", op, c), {HI, LO}, old);
      start = (c == inj);
      if (c == inj) begin MDUOp = inj_op; A = inj_a; B = $urandom; end
    end
    @(negedge clk);
    start = 1'b0;
    check($sformatf("busy_done op%0d", op), {63'b0, busy}, 64'd0);
    check($sformatf("hilo op%0d", op), {HI, LO}, {m_hi, m_lo});
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] bnd [5];
    bnd = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
    case ($urandom % 4)
      0, 1:    return $urandom;
      2:       return $urandom_range(0, 20);
      default: return bnd[$urandom % 5];
    endcase
  endfunction

  initial begin
    reset = 1'b1; start = 1'b0; MDUOp = '0; A = '0; B = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", {63'b0, busy}, 64'd0);
    check("rst_hilo", {HI, LO}, 64'd0);
    reset = 1'b0;

    run_op(4'd0, 32'hFFFF_FFFE, 32'd3, 0, 4'd0, 32'd0);
    check("t1_mult", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFA);
    run_op(4'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3, 4'd4, 32'hDEAD_BEEF);
    check("t2_multu_ign", {HI, LO}, 64'hFFFF_FFFE_0000_0001);
    run_op(4'd2, 32'hFFFF_FFF9, 32'd2, 0, 4'd0, 32'd0);
    check("t3_div", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op(4'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0, 4'd0, 32'd0);
    check("t3_div_ovf", {HI, LO}, 64'h0000_0000_8000_0000);
    run_op(4'd3, 32'h0000_1234, 32'd0, 0, 4'd0, 32'd0);
    check("t4_divu_zero", {HI, LO}, 64'h0000_1234_FFFF_FFFF);
    run_op(4'd5, 32'hA5A5_A5A5, 32'd0, 0, 4'd0, 32'd0);
    check("t5_mtlo", {32'b0, LO}, 64'hA5A5_A5A5);

    // Reset in cycle 2 of a MULT aborts it for good.
    start = 1'b1; MDUOp = 4'd0; A = 32'd2; B = 32'd3;
    @(negedge clk); start = 1'b0;
    check("t5_busy_c1", {63'b0, busy}, 64'd1);
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    m_hi = '0; m_lo = '0;
    check("t5_abort_busy", {63'b0, busy}, 64'd0);
    check("t5_abort_hilo", {HI, LO}, 64'd0);
    repeat (8) begin
      @(negedge clk);
      check("t5_no_commit", {busy, HI, LO}, 65'd0);
    end

    // Reset coinciding with start wins.
    run_op(4'd4, 32'h1111_2222, 32'd0, 0, 4'd0, 32'd0);
    start = 1'b1; MDUOp = 4'd1; A = 32'd7; B = 32'd9; reset = 1'b1;
    @(negedge clk); start = 1'b0; reset = 1'b0;
    m_hi = '0; m_lo = '0;
    check("rst_start_busy", {63'b0, busy}, 64'd0);
    check("rst_start_hilo", {HI, LO}, 64'd0);
    @(negedge clk);
    check("rst_start_busy2", {63'b0, busy}, 64'd0);

    run_op(4'd5, 32'hFFFF_FFFF, 32'd0, 0, 4'd0, 32'd0);
    run_op(4'd4, 32'h0, 32'd0, 0, 4'd0, 32'd0);
    run_op(4'd7, 32'd1, 32'd1, 0, 4'd0, 32'd0);
`ifdef MDU_MADD_EN
    check("t6_maddu", {HI, LO}, 64'h0000_0001_0000_0000);
`else
    check("t6_maddu_noop", {HI, LO}, 64'h0000_0000_FFFF_FFFF);
`endif

    for (int i = 0; i < 80; i++) begin
      logic [3:0]  op, iop;
      logic [31:0] a, b, ia;
      int          inj;
      op  = 4'($urandom_range(0, 15));
      a   = pick();
      b   = pick();
      iop = 4'($urandom_range(0, 15));
      ia  = $urandom;
      inj = ($urandom % 3 == 0) ? int'($urandom_range(1, 10)) : 0;
      run_op(op, a, b, inj, iop, ia);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mdu_core.md
# mdu_core

Multi-cycle multiply/divide unit with architectural HI/LO registers, parametrised in operand width and per-operation latency. It sits beside the combinational ALU in the EX stage. It accepts one operation per start strobe, holds `busy` for a fixed latency so the hazard unit stalls dependent `mfhi`/`mflo` and further MDU instructions, then commits the results atomically to HI/LO.

## Interface

Parameters:
- `WIDTH`, default 32: operand and HI/LO width.
- `MULT_CYCLES`, default 5: busy cycles for multiply-class operations. Must be ≥1.
- `DIV_CYCLES`, default 10: busy cycles for divide operations. Must be ≥1.

Ports:
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  operation strobe, sampled on the clock edge.
- `MDUOp`  in  4  operation code, valid with `start`.
- `A`  in  WIDTH  rs operand.
- `B`  in  WIDTH  rt operand.
- `busy`  out  1  operation in flight.
- `HI`  out  WIDTH  HI register.
- `LO`  out  WIDTH  LO register.

## Operation

MDUOp encoding:
- `MULT` = 0, `MULTU` = 1, `DIV` = 2, `DIVU` = 3: timed operations.
- `MTHI` = 4, `MTLO` = 5: immediate writes.
- `MADD` = 6, `MADDU` = 7, `MSUB` = 8, `MSUBU` = 9: timed operations, only when the feature below is compiled in.
- All other codes: no-op.

States are IDLE and RUN.
- **IDLE + `start` + timed op:**
  - Compute the result from A/B at the start edge.
  - Latch it into the pending {`hi_q`, `lo_q`} registers.
  - Load the counter with the latency for that op.
  - Go to RUN.
- **IDLE + `start` + MTHI/MTLO:** HI (or LO) ← A on that edge. State stays IDLE and `busy` stays 0.
- **RUN:**
  - Decrement the counter each edge.
  - On the edge where the counter reaches its final count, copy {`hi_q`, `lo_q`} to {HI, LO} and return to IDLE.
  - `start` is ignored in RUN, whatever the op. Upstream must stall.

Arithmetic:
- **MULT/MULTU:** the 2·WIDTH product, signed or unsigned. HI = upper half, LO = lower half.
- **DIV/DIVU:** LO = quotient, HI = remainder.
  - Signed division truncates toward zero. The remainder takes the dividend's sign.
  - Most-negative / −1: LO = most-negative value, HI = 0. No trap.
  - Divide by zero (B = 0): LO = all ones, HI = A. Full DIV_CYCLES latency still applies.
- **MADD/MSUB:** {HI,LO} ± product, modulo 2^(2·WIDTH).
  - Uses the HI/LO values current at the start edge.

Reset:
- HI = 0, LO = 0, `busy` = 0, state = IDLE, counter = 0, pending registers = 0.
- Reset mid-RUN aborts the operation. The pending result is never committed.

## Timing

- `start` is sampled at edge E0 (end of cycle 0).
- `busy` = 1 during cycles 1..N, where N = MULT_CYCLES or DIV_CYCLES.
- HI/LO update at edge EN. `busy` = 0 and new values are visible from cycle N+1.
- Back-to-back operation: a new `start` may be presented in cycle N+1. Throughput is one operation per N+1 cycles.
- MTHI/MTLO: value visible in cycle 1, with no `busy` pulse.
- HI/LO outputs are registered and never show partial results.
- `reset` asserted at the same edge as `start` wins.

## Configuration

- `MDU_MADD_EN` defined: MADD/MADDU/MSUB/MSUBU decode as timed operations with MULT_CYCLES latency.
- `MDU_MADD_EN` undefined: codes 6–9 are no-ops. `busy` stays 0 and HI/LO are unchanged. Accumulate datapath logic is removed.

## Structure

- Package `mdu_pkg`:
  - MDUOp localparams (`MDU_MULT` … `MDU_MSUBU`).
  - State enum `{IDLE, RUN}`.
  - `MDU_OP_W` = 4.
- Sub-module `mdu_div`: combinational signed/unsigned divider, parametrised by WIDTH. It carries the divide-by-zero and overflow rules. The top level holds the FSM, counter, pending registers and HI/LO.

## Test plan

1. `MULT`, A = 0xFFFFFFFE (−2), B = 3, default params → `busy` high for cycles 1–5; cycle 6: HI = 0xFFFFFFFF, LO = 0xFFFFFFFA.
2. `MULTU`, A = 0xFFFFFFFF, B = 0xFFFFFFFF → HI = 0xFFFFFFFE, LO = 0x00000001 after 5 busy cycles. A `start`/`MTHI` in cycle 3 is ignored.
3. `DIV` A = −7 (0xFFFFFFF9), B = 2 → after 10 busy cycles, LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
   - `DIV` 0x80000000 / 0xFFFFFFFF → LO = 0x80000000, HI = 0.
4. `DIVU` A = 0x1234, B = 0 → after 10 busy cycles, LO = 0xFFFFFFFF, HI = 0x1234.
5. `MTLO` A = 0xA5A5A5A5 → LO = 0xA5A5A5A5 in the next cycle, `busy` never asserts.
   - Then `MULT` 2×3 with `reset` asserted in cycle 2 → HI = LO = 0, `busy` = 0 in cycle 3, no later commit.
6. With `MDU_MADD_EN`: HI:LO = 0:0xFFFFFFFF, `MADDU` 1×1 → HI = 1, LO = 0.
   - Without `MDU_MADD_EN`: the same stimulus leaves HI:LO unchanged and `busy` = 0.
